// File: rtl/tx_pkg.sv
// Shared types and line levels for the serial byte transmitter and its FIFO.
package tx_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  localparam int   DATA_BITS = 8;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;
  localparam logic IDLE_LVL  = 1'b1;

endpackage

// File: rtl/tx_fifo.sv
// Byte FIFO feeding the transmitter; head entry is visible combinationally so a
// pop and the shift-register load happen on the same edge.
module tx_fifo
  import tx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [DATA_BITS-1:0]   push_data,
  input  logic                   pop,
  output logic [DATA_BITS-1:0]   head_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr_reg;
  logic [AW-1:0]        rd_ptr_reg;
  logic [AW:0]          count_reg;
  logic                 do_push;
  logic                 do_pop;

  assign full      = (count_reg == (AW+1)'(DEPTH));
  assign empty     = (count_reg == '0);
  assign count     = count_reg;
  assign head_data = mem[rd_ptr_reg];
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;

  // Storage needs no reset: the pointers define which entries are meaningful.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/tx_block.sv
// Serial byte transmitter: idle-high line, one start bit, eight data bits LSB
// first, one stop bit, CLKS_PER_BIT clocks per bit, fed from a small FIFO.
module tx_block
  import tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [7:0]                  tx_data,
  input  logic                        data_valid,
  output logic                        tx_ready,
  output logic                        serial_out,
  output logic                        tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overrun_error,
  input  logic                        clear_error
);

  localparam int             CW       = $clog2(CLKS_PER_BIT);
  localparam int             BW       = $clog2(DATA_BITS);
  localparam logic [CW-1:0]  CLK_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0]  BIT_LAST = BW'(DATA_BITS - 1);

  tx_state_t            state_reg,   state_next;
  logic [CW-1:0]        clk_cnt_reg, clk_cnt_next;
  logic [BW-1:0]        bit_cnt_reg, bit_cnt_next;
  logic [DATA_BITS-1:0] shift_reg,   shift_next;
  logic                 serial_reg,  serial_next;
  logic                 overrun_reg, overrun_next;

  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] head_data;

  assign tx_ready      = !fifo_full;
  assign fifo_push     = data_valid && tx_ready;
  assign serial_out    = serial_reg;
  assign overrun_error = overrun_reg;
  assign tx_busy       = (state_reg != IDLE) || (fifo_count != '0);

  tx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_data(tx_data),
    .pop      (fifo_pop),
    .head_data(head_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      clk_cnt_reg <= '0;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      serial_reg  <= IDLE_LVL;
      overrun_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      clk_cnt_reg <= clk_cnt_next;
      bit_cnt_reg <= bit_cnt_next;
      shift_reg   <= shift_next;
      serial_reg  <= serial_next;
      overrun_reg <= overrun_next;
    end
  end

  // The line level is registered from the current state, so it trails the
  // state by one clock; every bit still lasts exactly CLKS_PER_BIT cycles.
  always_comb begin
    state_next   = state_reg;
    clk_cnt_next = clk_cnt_reg;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    serial_next  = IDLE_LVL;
    fifo_pop     = 1'b0;
    case (state_reg)
      IDLE: begin
        serial_next = IDLE_LVL;
        if (!fifo_empty) begin
          fifo_pop     = 1'b1;
          shift_next   = head_data;
          clk_cnt_next = '0;
          state_next   = START;
        end
      end
      START: begin
        serial_next = START_LVL;
        if (clk_cnt_reg == CLK_LAST) begin
          clk_cnt_next = '0;
          bit_cnt_next = '0;
          state_next   = DATA;
        end else begin
          clk_cnt_next = clk_cnt_reg + CW'(1);
        end
      end
      DATA: begin
        serial_next = shift_reg[0];
        if (clk_cnt_reg == CLK_LAST) begin
          clk_cnt_next = '0;
          shift_next   = shift_reg >> 1;
          if (bit_cnt_reg == BIT_LAST) begin
            state_next = STOP;
          end else begin
            bit_cnt_next = bit_cnt_reg + BW'(1);
          end
        end else begin
          clk_cnt_next = clk_cnt_reg + CW'(1);
        end
      end
      STOP: begin
        serial_next = STOP_LVL;
        if (clk_cnt_reg == CLK_LAST) begin
          clk_cnt_next = '0;
          // Chain straight into the next frame when a byte is waiting.
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            shift_next = head_data;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end else begin
          clk_cnt_next = clk_cnt_reg + CW'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    overrun_next = overrun_reg;
    if (clear_error) begin
      overrun_next = 1'b0;
    end else if (data_valid && !tx_ready) begin
      overrun_next = 1'b1;
    end
  end

endmodule

// File: tb/tb_tx_block.sv
// Directed bench for tx_block: cycle-exact frame checks at 10 clocks/bit and a
// randomised stream at 16 clocks/bit decoded by a behavioural receiver.
module tb_tx_block;

  localparam int C1    = 10;
  localparam int C2    = 16;
  localparam int DEPTH = 4;
  localparam int FL    = 10 * C1;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data,   tx_data2;
  logic       data_valid, data_valid2;
  logic       clear_error, clear_error2;
  logic       tx_ready,  tx_ready2;
  logic       serial_out, serial_out2;
  logic       tx_busy,   tx_busy2;
  logic [2:0] fifo_count, fifo_count2;
  logic       overrun_error, overrun_error2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tx_block #(.CLKS_PER_BIT(C1), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .data_valid(data_valid),
    .tx_ready(tx_ready), .serial_out(serial_out), .tx_busy(tx_busy),
    .fifo_count(fifo_count), .overrun_error(overrun_error), .clear_error(clear_error)
  );

  tx_block #(.CLKS_PER_BIT(C2), .FIFO_DEPTH(DEPTH)) dut16 (
    .clk(clk), .rst(rst), .tx_data(tx_data2), .data_valid(data_valid2),
    .tx_ready(tx_ready2), .serial_out(serial_out2), .tx_busy(tx_busy2),
    .fifo_count(fifo_count2), .overrun_error(overrun_error2), .clear_error(clear_error2)
  );

  // Behavioural receiver on the 16 clocks/bit line, sampling at bit centres.
  int         m_cnt  = 0;
  logic       m_busy = 1'b0;
  logic [7:0] m_sh   = 8'h00;
  int         m_ferr = 0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];

  always @(negedge clk) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
    end else if (!m_busy) begin
      if (serial_out2 === 1'b0) begin
        m_busy <= 1'b1;
        m_cnt  <= 1;
      end
    end else begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == C2/2 && serial_out2 !== 1'b0) begin
        m_ferr <= m_ferr + 1;
        m_busy <= 1'b0;
      end
      if (m_cnt > C2/2 && m_cnt < C2/2 + 9*C2 && (m_cnt - C2/2) % C2 == 0)
        m_sh <= {serial_out2, m_sh[7:1]};
      if (m_cnt == C2/2 + 9*C2) begin
        if (serial_out2 !== 1'b1) m_ferr <= m_ferr + 1;
        else rx_q.push_back(m_sh);
        m_busy <= 1'b0;
      end
    end
  end

  // Steps through frame cycles k0..k1, where cycle k is the negedge k clocks
  // after the start bit first appears; checks the start edge and bit centres.
  task automatic check_frame(input logic [7:0] b, input int k0, input int k1, input string name);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    if (k0 == 0) begin
      n_checks++;
      if (serial_out !== 1'b1) begin
        n_fail++;
        $display("FAIL %s pre_start: serial_out=%b expected 1", name, serial_out);
      end
    end
    for (int k = k0; k <= k1; k++) begin
      @(negedge clk);
      if (k == 0 || k % C1 == C1/2) begin
        n_checks++;
        if (serial_out !== fr[k / C1]) begin
          n_fail++;
          $display("FAIL %s cycle %0d: serial_out=%b expected %b", name, k, serial_out, fr[k / C1]);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tx_data = 8'h00; data_valid = 1'b0; clear_error = 1'b0;
    tx_data2 = 8'h00; data_valid2 = 1'b0; clear_error2 = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({serial_out, tx_ready, tx_busy, fifo_count, overrun_error} !== 7'b1100000) begin
      n_fail++;
      $display("FAIL reset_state: {ser,rdy,busy,cnt,ovr}=%b expected 1100000",
               {serial_out, tx_ready, tx_busy, fifo_count, overrun_error});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({serial_out, tx_ready, tx_busy, fifo_count} !== 6'b110000) begin
      n_fail++;
      $display("FAIL after_reset: {ser,rdy,busy,cnt}=%b expected 110000",
               {serial_out, tx_ready, tx_busy, fifo_count});
    end
    $display("test_reset done");
  endtask

  task automatic test_single();
    @(negedge clk); tx_data = 8'hA5; data_valid = 1'b1;
    @(negedge clk); data_valid = 1'b0;
    n_checks++;
    if (fifo_count !== 3'd1 || tx_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_push: cnt=%0d busy=%b expected 1 1", fifo_count, tx_busy);
    end
    @(negedge clk);
    n_checks++;
    if (fifo_count !== 3'd0) begin
      n_fail++;
      $display("FAIL single_pop: cnt=%0d expected 0", fifo_count);
    end
    check_frame(8'hA5, 0, FL-2, "single");
    n_checks++;
    if (tx_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_busy_end: busy=%b expected 1", tx_busy);
    end
    @(negedge clk);
    n_checks++;
    if (tx_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_busy_fall: busy=%b expected 0", tx_busy);
    end
    $display("test_single done: byte a5");
  endtask

  task automatic test_back_to_back();
    @(negedge clk); tx_data = 8'h00; data_valid = 1'b1;
    @(negedge clk); tx_data = 8'hFF;
    @(negedge clk); tx_data = 8'h3C;
    n_checks++;
    if (serial_out !== 1'b1) begin
      n_fail++;
      $display("FAIL burst_pre_start: serial_out=%b expected 1", serial_out);
    end
    @(negedge clk); tx_data = 8'hC3;
    n_checks++;
    if (serial_out !== 1'b0) begin
      n_fail++;
      $display("FAIL burst_start: serial_out=%b expected 0", serial_out);
    end
    @(negedge clk); data_valid = 1'b0;
    n_checks++;
    if (fifo_count !== 3'd3 || tx_ready !== 1'b1 || overrun_error !== 1'b0) begin
      n_fail++;
      $display("FAIL burst_count: cnt=%0d rdy=%b ovr=%b expected 3 1 0", fifo_count, tx_ready, overrun_error);
    end
    check_frame(8'h00, 2, FL-1, "burst0");
    check_frame(8'hFF, 0, FL-1, "burst1");
    check_frame(8'h3C, 0, FL-1, "burst2");
    check_frame(8'hC3, 0, FL-1, "burst3");
    n_checks++;
    if (tx_busy !== 1'b0 || fifo_count !== 3'd0) begin
      n_fail++;
      $display("FAIL burst_drain: busy=%b cnt=%0d expected 0 0", tx_busy, fifo_count);
    end
    $display("test_back_to_back done: 00 ff 3c c3");
  endtask

  task automatic test_overrun();
    @(negedge clk); tx_data = 8'h11; data_valid = 1'b1;
    @(negedge clk); tx_data = 8'h22;
    @(negedge clk); tx_data = 8'h33;
    @(negedge clk); tx_data = 8'h44;
    @(negedge clk); tx_data = 8'h55;
    @(negedge clk);
    n_checks++;
    if (fifo_count !== 3'd4 || tx_ready !== 1'b0 || overrun_error !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_full: cnt=%0d rdy=%b ovr=%b expected 4 0 0", fifo_count, tx_ready, overrun_error);
    end
    tx_data = 8'h66;
    @(negedge clk); data_valid = 1'b0;
    n_checks++;
    if (overrun_error !== 1'b1 || fifo_count !== 3'd4) begin
      n_fail++;
      $display("FAIL ovr_set: ovr=%b cnt=%0d expected 1 4", overrun_error, fifo_count);
    end
    @(negedge clk);
    n_checks++;
    if (overrun_error !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_sticky: ovr=%b expected 1", overrun_error);
    end
    clear_error = 1'b1;
    @(negedge clk);
    n_checks++;
    if (overrun_error !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_clear: ovr=%b expected 0", overrun_error);
    end
    tx_data = 8'h77; data_valid = 1'b1;
    @(negedge clk); data_valid = 1'b0; clear_error = 1'b0;
    n_checks++;
    if (overrun_error !== 1'b0 || fifo_count !== 3'd4) begin
      n_fail++;
      $display("FAIL ovr_clear_wins: ovr=%b cnt=%0d expected 0 4", overrun_error, fifo_count);
    end
    check_frame(8'h11, 7, FL-1, "ovr0");
    check_frame(8'h22, 0, FL-1, "ovr1");
    check_frame(8'h33, 0, FL-1, "ovr2");
    check_frame(8'h44, 0, FL-1, "ovr3");
    check_frame(8'h55, 0, FL-1, "ovr4");
    n_checks++;
    if (tx_busy !== 1'b0 || overrun_error !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_drain: busy=%b ovr=%b expected 0 0", tx_busy, overrun_error);
    end
    $display("test_overrun done: 11..55 sent, 66 and 77 dropped");
  endtask

  task automatic test_push_on_pop();
    @(negedge clk); tx_data = 8'h12; data_valid = 1'b1;
    @(negedge clk); tx_data = 8'h34;
    @(negedge clk); tx_data = 8'h56;
    @(negedge clk); tx_data = 8'h78;
    @(negedge clk); data_valid = 1'b0;
    check_frame(8'h12, 2, FL-2, "pp0");
    n_checks++;
    if (fifo_count !== 3'd3) begin
      n_fail++;
      $display("FAIL pp_before: cnt=%0d expected 3", fifo_count);
    end
    tx_data = 8'h9A; data_valid = 1'b1;
    @(negedge clk); data_valid = 1'b0;
    n_checks++;
    if (fifo_count !== 3'd3 || overrun_error !== 1'b0 || serial_out !== 1'b1) begin
      n_fail++;
      $display("FAIL pp_after: cnt=%0d ovr=%b ser=%b expected 3 0 1", fifo_count, overrun_error, serial_out);
    end
    check_frame(8'h34, 0, FL-1, "pp1");
    check_frame(8'h56, 0, FL-1, "pp2");
    check_frame(8'h78, 0, FL-1, "pp3");
    check_frame(8'h9A, 0, FL-1, "pp4");
    n_checks++;
    if (tx_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL pp_drain: busy=%b expected 0", tx_busy);
    end
    $display("test_push_on_pop done");
  endtask

  task automatic test_reset_mid_frame();
    @(negedge clk); tx_data = 8'h5A; data_valid = 1'b1;
    @(negedge clk); tx_data = 8'hEE;
    @(negedge clk); data_valid = 1'b0;
    check_frame(8'h5A, 0, 4*C1 + C1/2, "rst5a");
    n_checks++;
    if (fifo_count !== 3'd1 || tx_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre: cnt=%0d busy=%b expected 1 1", fifo_count, tx_busy);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({serial_out, fifo_count, tx_busy, tx_ready} !== 6'b100001) begin
      n_fail++;
      $display("FAIL rst_async: {ser,cnt,busy,rdy}=%b expected 100001",
               {serial_out, fifo_count, tx_busy, tx_ready});
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (serial_out !== 1'b1 || tx_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_release: ser=%b busy=%b expected 1 0", serial_out, tx_busy);
    end
    tx_data = 8'h81; data_valid = 1'b1;
    @(negedge clk); data_valid = 1'b0;
    @(negedge clk);
    check_frame(8'h81, 0, FL-1, "rst81");
    n_checks++;
    if (tx_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_drain: busy=%b expected 0", tx_busy);
    end
    $display("test_reset_mid_frame done: 81 sent after reset");
  endtask

  task automatic test_random_stream();
    int guard;
    int nmin;
    logic [7:0] b;
    rx_q.delete();
    exp_q.delete();
    for (int i = 0; i < 200; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      guard = 0;
      while (!tx_ready2 && guard < 2000) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 2000) begin
        n_checks++;
        n_fail++;
        $display("FAIL rand_ready_timeout: rdy=%b expected 1", tx_ready2);
        break;
      end
      b = 8'($urandom_range(0, 255));
      tx_data2 = b; data_valid2 = 1'b1;
      exp_q.push_back(b);
      @(negedge clk); data_valid2 = 1'b0;
    end
    guard = 0;
    while (tx_busy2 && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    repeat (2 * C2) @(negedge clk);
    n_checks++;
    if (tx_busy2 !== 1'b0 || rx_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL rand_count: busy=%b received=%0d expected %0d", tx_busy2, rx_q.size(), exp_q.size());
    end
    nmin = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < nmin; i++) begin
      n_checks++;
      if (rx_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL rand_byte %0d: got %h expected %h", i, rx_q[i], exp_q[i]);
      end
    end
    n_checks++;
    if (m_ferr != 0 || overrun_error2 !== 1'b0) begin
      n_fail++;
      $display("FAIL rand_errors: framing=%0d ovr=%b expected 0 0", m_ferr, overrun_error2);
    end
    $display("test_random_stream done: %0d bytes", exp_q.size());
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_push_on_pop();
    test_reset_mid_frame();
    test_random_stream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
